td4_program_rom: RTL
====================

// Module: td4_program_rom
// PURPOSE
//  Program-memory responder for the TD4 CPU: answers the CPU's 4-bit instruction address with an 8-bit instruction word.
//  Holds 16x8 instruction storage, loadable at run time over a byte-wide valid/ready load port.
//  Owns the CPU reset: keeps the CPU in reset until a full 16-byte image is present, then releases it.
// PARAMETERS
//  DEPTH  16  instruction words; always 2**AW
//  AW     4   address width; matches the CPU address bus
//  DW     8   instruction width; {op[7:4], im[3:0]}
// PORTS
//  clk         in   1   single clock; all state changes on rising edge
//  rst         in   1   asynchronous, active-low reset
//  addr        in   AW  instruction address from the CPU
//  data        out  DW  instruction word to the CPU
//  cpu_rst     out  1   active-low reset to the CPU; registered
//  load_start  in   1   begin or restart an image load
//  load_valid  in   1   load_data holds a byte
//  load_data   in   DW  byte to store
//  load_ready  out  1   high in LOAD; a byte transfers when load_valid & load_ready
//  load_done   out  1   one-cycle pulse on the cycle after the 16th byte is written
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE, wr_ptr=0, cpu_rst=0, load_done=0, mem cleared to 8'h00.
//  Read port: data = mem[addr], combinational, in every state, 0 cycles latency.
//  Write-vs-read collision: when addr==wr_ptr during a write, data shows the old byte that cycle and the new byte the next.
//  States:
//   IDLE: load_ready=0, cpu_rst=0. load_start=1 -> LOAD with wr_ptr=0.
//   LOAD: load_ready=1, cpu_rst=0. A transfer writes mem[wr_ptr]<=load_data and increments wr_ptr.
//         A transfer at wr_ptr==15 -> RUN; wr_ptr wraps to 0; load_done=1 for the next cycle only.
//         load_start=1 in LOAD -> wr_ptr=0 and stay in LOAD.
//         load_start wins over a same-cycle transfer; that byte is dropped and not acknowledged as stored.
//         load_valid=0 cycles: hold with no write. There is no timeout.
//   RUN:  load_ready=0. cpu_rst=1 starting the cycle after RUN is entered (registered).
//         load_start=1 -> LOAD, wr_ptr=0; cpu_rst=0 on the next cycle. Memory keeps its old contents until overwritten.
//  load_valid outside LOAD is ignored.
//  Reset asserted mid-load discards the partial image; memory returns to its reset contents.
//  wr_ptr is AW bits; increments wrap modulo DEPTH.
// CONFIGURATION
//  TD4_ROM_DEFAULT_PROG_EN
//   defined: reset loads mem with TD4_DEFAULT_PROG and the state goes to RUN.
//            cpu_rst goes to 1 on the first clock edge after rst deasserts, so the CPU boots without a load.
//   undefined: reset clears mem to 8'h00 and the state goes to IDLE; the CPU stays in reset until the first complete load.
// STRUCTURE
//  Package td4_pkg:
//   - TD4_AW=4, TD4_DW=8, TD4_DEPTH=16
//   - rom_state_t enum {IDLE, LOAD, RUN}
//   - TD4_DEFAULT_PROG[16]: 0:8'hB3 (OUT 3), 1:8'hBC (OUT 12), 2:8'hF0 (JMP 0), 3..15:8'h00
//  Sub-module td4_prog_mem: 16xDW flop array with one synchronous write port, an async-reset init value and a combinational read.
//  The FSM, wr_ptr and cpu_rst logic stay in td4_program_rom.
// TESTING
//  1. Reset with the macro undefined -> data=8'h00 for every addr; cpu_rst=0; state IDLE; load_ready=0.
//  2. load_start, then 16 back-to-back bytes 8'h10..8'h1F -> load_done pulses exactly once; cpu_rst=1 the following cycle; addr=5 reads 8'h15.
//  3. Valid gaps: drive load_valid only on alternate cycles -> only acknowledged bytes are written; still 16 transfers to RUN.
//  4. After 7 bytes, load_start together with load_valid (byte 8'hAA) -> 8'hAA is not stored; wr_ptr=0; the next byte lands at addr 0.
//  5. In RUN, assert load_start -> cpu_rst=0 the next cycle; the old image stays readable until overwritten.
//     Write 8'h77 at addr 0 while addr=0 -> data is the old value that cycle and 8'h77 the next.
//  6. Assert rst mid-load (wr_ptr=9) -> outputs go to reset values immediately, without waiting for clk.
//     With TD4_ROM_DEFAULT_PROG_EN defined: addr 0/1/2 read B3/BC/F0, and cpu_rst=1 one edge after release.

Source files
------------

// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared widths, ROM FSM states and default boot image for the TD4 program ROM
package td4_pkg;

    localparam int TD4_AW    = 4;
    localparam int TD4_DW    = 8;
    localparam int TD4_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } rom_state_t;

    // OUT 3 / OUT 12 / JMP 0: a blinking boot loop for bring-up
    localparam logic [TD4_DW-1:0] TD4_DEFAULT_PROG [TD4_DEPTH] = '{
        8'hB3, 8'hBC, 8'hF0, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/td4_prog_mem.sv
// rtl/td4_prog_mem.sv - 16xDW flop array, one sync write port, combinational read (macro TD4_ROM_DEFAULT_PROG_EN)
module td4_prog_mem
    import td4_pkg::*;
#(
    parameter int AW    = TD4_AW,
    parameter int DW    = TD4_DW,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef TD4_ROM_DEFAULT_PROG_EN
                mem[i] <= TD4_DEFAULT_PROG[i];
`else
                mem[i] <= '0;
`endif
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to raddr shows up only after the edge
    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_program_rom.sv
// rtl/td4_program_rom.sv - TD4 program memory with byte load port and CPU reset ownership (macro TD4_ROM_DEFAULT_PROG_EN)
module td4_program_rom
    import td4_pkg::*;
#(
    parameter int AW    = TD4_AW,
    parameter int DW    = TD4_DW,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          cpu_rst,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          load_done
);

`ifdef TD4_ROM_DEFAULT_PROG_EN
    localparam rom_state_t RESET_STATE = RUN;
`else
    localparam rom_state_t RESET_STATE = IDLE;
`endif

    rom_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic          xfer;
    logic          last_xfer;

    // A restart request takes priority, so a byte offered with it is dropped
    assign xfer       = (state == LOAD) && load_valid && !load_start;
    assign last_xfer  = xfer && (wr_ptr == AW'(DEPTH - 1));
    assign load_ready = (state == LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RESET_STATE;
            wr_ptr    <= '0;
            cpu_rst   <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= last_xfer;
            cpu_rst   <= (state == RUN) && !load_start;
            if (load_start) begin
                state  <= LOAD;
                wr_ptr <= '0;
            end else if (xfer) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (last_xfer) begin
                    state <= RUN;
                end
            end
        end
    end

    td4_prog_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (xfer),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (addr),
        .rdata (data)
    );

endmodule
